vga_sync_gen: RTL



---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/pix_tick_gen.sv | 38 +++
 rtl/vga_sync_gen.sv | 102 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants used by the sync generator and the
// downstream graphics stages.
package vga_timing_pkg;

   localparam int COORD_W = 10;

   localparam int H_DISP_DEF = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;

   localparam int V_DISP_DEF = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int H_TOTAL = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int MAX_X = 640;
   localparam int MAX_Y = 480;

   function automatic logic in_window(input logic [COORD_W-1:0] v,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Mod-CLK_DIV divider producing a registered one-clk pixel-rate enable.
module pix_tick_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   output logic p_tick
);

   localparam logic [3:0] CNT_LAST = 4'(CLK_DIV - 1);

   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("pix_tick_gen: CLK_DIV must be in 1..16");
   end

   logic [3:0] cnt_q, cnt_d;
   logic       p_tick_q, p_tick_d;

   // The tick is registered from the terminal count, so the first pulse
   // appears CLK_DIV clks after reset release.
   always_comb begin
      cnt_d    = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
      p_tick_d = (cnt_q == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q    <= 4'd0;
         p_tick_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         p_tick_q <= p_tick_d;
      end
   end

   assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA horizontal/vertical timing generator: registered sync, visible-area flag,
// pixel coordinates and a frame-wrap pulse.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int H_DISP  = H_DISP_DEF,
   parameter int H_FP    = H_FP_DEF,
   parameter int H_SYNC  = H_SYNC_DEF,
   parameter int H_BP    = H_BP_DEF,
   parameter int V_DISP  = V_DISP_DEF,
   parameter int V_FP    = V_FP_DEF,
   parameter int V_SYNC  = V_SYNC_DEF,
   parameter int V_BP    = V_BP_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               p_tick,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               frame_tick
);

   localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

   if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
      $error("vga_sync_gen: H/V totals must fit in 10-bit counters");
   end

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOT - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOT - 1);
   localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISP);
   localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISP);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISP + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISP + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISP + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISP + V_FP + V_SYNC - 1);

   logic               tick;
   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               video_on_q, video_on_d;
   logic               frame_tick_q, frame_tick_d;

   pix_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .p_tick  (tick)
   );

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (tick) begin
         if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
         end else begin
            x_d = x_q + COORD_W'(1);
         end
      end
      // Decoded from the next-state position so the flags line up with pixel_x/y.
      hsync_d      = !in_window(x_d, HS_FIRST, HS_LAST);
      vsync_d      = !in_window(y_d, VS_FIRST, VS_LAST);
      video_on_d   = (x_d < H_VIS) && (y_d < V_VIS);
      frame_tick_d = tick && (x_q == H_LAST) && (y_q == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         x_q          <= '0;
         y_q          <= '0;
         hsync_q      <= 1'b1;
         vsync_q      <= 1'b1;
         video_on_q   <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         video_on_q   <= video_on_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign p_tick     = tick;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign video_on   = video_on_q;
   assign pixel_x    = x_q;
   assign pixel_y    = y_q;
   assign frame_tick = frame_tick_q;

endmodule
